// File: rtl/block_row_store_pkg.sv
// Shared constants and types for the breakout wall row store and the block painter.
package block_row_store_pkg;

   localparam int unsigned BLOCKS_PER_ROW = 13;
   localparam int unsigned NUM_ROWS       = 15;
   localparam int unsigned FILLED_ROWS    = 15;
   localparam int unsigned CNT_W          = 8;
   // Width of a per-row block count; holds 0..BLOCKS_PER_ROW.
   localparam int unsigned HIT_W          = 4;

   typedef logic [BLOCKS_PER_ROW-1:0] row_t;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StRun
   } state_e;

endpackage

// File: rtl/block_row_store_if.sv
// Painter / game-control facing bundle of the row store.
interface block_row_store_if #(
   parameter int unsigned CntW = block_row_store_pkg::CNT_W
) ();
   import block_row_store_pkg::*;

   logic               new_frame;
   logic               go_next_line;
   logic               write_block_line_state;
   row_t               new_block_line_state;
   logic               level_start;

   row_t               block_line_state;
   logic               busy;
   logic [HIT_W-1:0]   blocks_hit;
   logic               hit_valid;
   logic [CntW-1:0]    blocks_remaining;
   logic               level_cleared;

   modport master (
      output new_frame, go_next_line, write_block_line_state, new_block_line_state, level_start,
      input  block_line_state, busy, blocks_hit, hit_valid, blocks_remaining, level_cleared
   );

   modport slave (
      input  new_frame, go_next_line, write_block_line_state, new_block_line_state, level_start,
      output block_line_state, busy, blocks_hit, hit_valid, blocks_remaining, level_cleared
   );

endinterface

// File: rtl/row_popcount.sv
// Combinational population count of one row mask.
module row_popcount
   import block_row_store_pkg::*;
(
   input  row_t             row_i,
   output logic [HIT_W-1:0] count_o
);

   // Sum the set bits of the row.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < BLOCKS_PER_ROW; i++) begin
         count_o = count_o + HIT_W'(row_i[i]);
      end
   end

endmodule

// File: rtl/block_row_store.sv
// Breakout wall backing store: one presence mask per row, fill at level start,
// collision write-back with hit accounting and level-cleared detection.
module block_row_store #(
   parameter int unsigned NUM_ROWS    = block_row_store_pkg::NUM_ROWS,
   parameter int unsigned FILLED_ROWS = block_row_store_pkg::FILLED_ROWS,
   parameter int unsigned CNT_W       = block_row_store_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   block_row_store_if.slave store_io
);
   import block_row_store_pkg::*;

   localparam int unsigned     PtrW      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [PtrW-1:0] LastRow   = PtrW'(NUM_ROWS - 1);
   localparam logic [CNT_W-1:0] FullCount = CNT_W'(FILLED_ROWS * BLOCKS_PER_ROW);

   state_e            state_q;
   row_t              rows_q [NUM_ROWS];
   logic [PtrW-1:0]   ptr_q;
   logic [PtrW-1:0]   fill_idx_q;
   logic [CNT_W-1:0]  remaining_q;
   logic [HIT_W-1:0]  hit_q;
   logic              hit_valid_q;
   logic              busy_q;
   logic              cleared_q;

   row_t              cur_row;
   row_t              lost_blocks;
   logic [PtrW-1:0]   ptr_adv;
   logic [HIT_W-1:0]  removed;
   logic              fill_ones;

   // Current row read, blocks lost by a write-back and the next pointer value.
   always_comb begin
      cur_row     = rows_q[ptr_q];
      // New bits are never added: only old & ~new can change.
      lost_blocks = cur_row & ~store_io.new_block_line_state;
      fill_ones   = (32'(fill_idx_q) < FILLED_ROWS);
      ptr_adv     = ptr_q;
      if (store_io.new_frame) begin
         ptr_adv = '0;
      end else if (store_io.go_next_line && (ptr_q != LastRow)) begin
         ptr_adv = ptr_q + PtrW'(1);
      end
   end

   row_popcount u_popcount (
      .row_i   (lost_blocks),
      .count_o (removed)
   );

   // Level FSM with row storage, pointer, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         for (int i = 0; i < NUM_ROWS; i++) begin
            rows_q[i] <= '0;
         end
         ptr_q       <= '0;
         fill_idx_q  <= '0;
         remaining_q <= '0;
         hit_q       <= '0;
         hit_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         cleared_q   <= 1'b0;
      end else begin
         hit_q       <= '0;
         hit_valid_q <= 1'b0;
         if (store_io.level_start) begin
            // Restart the fill from any state.
            state_q     <= StFill;
            fill_idx_q  <= '0;
            ptr_q       <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b1;
            cleared_q   <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  ptr_q     <= ptr_adv;
                  cleared_q <= 1'b0;
               end
               StFill: begin
                  rows_q[fill_idx_q] <= fill_ones ? '1 : '0;
                  fill_idx_q         <= fill_idx_q + PtrW'(1);
                  if (fill_idx_q == LastRow) begin
                     state_q     <= StRun;
                     busy_q      <= 1'b0;
                     remaining_q <= FullCount;
                     ptr_q       <= '0;
                  end
               end
               StRun: begin
                  if (store_io.write_block_line_state) begin
                     // Write targets the pre-advance row.
                     rows_q[ptr_q] <= cur_row & store_io.new_block_line_state;
                     remaining_q   <= remaining_q - CNT_W'(removed);
                     hit_q         <= removed;
                     hit_valid_q   <= (removed != '0);
                  end
                  ptr_q     <= ptr_adv;
                  cleared_q <= (remaining_q == '0);
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign store_io.block_line_state = cur_row;
   assign store_io.busy             = busy_q;
   assign store_io.blocks_hit       = hit_q;
   assign store_io.hit_valid        = hit_valid_q;
   assign store_io.blocks_remaining = remaining_q;
   assign store_io.level_cleared    = cleared_q;

endmodule

// File: tb/tb_block_row_store.sv
// Bench for block_row_store: a wall-level model checked every cycle on the default
// instance, directed literal checks on both a default and a two-row instance.
module tb_block_row_store;
   import block_row_store_pkg::*;

   localparam int MIdle = 0;
   localparam int MFill = 1;
   localparam int MRun  = 2;
   localparam row_t AllOnes = '1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   block_row_store_if #(.CntW(CNT_W)) bus  ();
   block_row_store_if #(.CntW(CNT_W)) bus2 ();

   block_row_store #(
      .NUM_ROWS    (NUM_ROWS),
      .FILLED_ROWS (FILLED_ROWS),
      .CNT_W       (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .store_io (bus.slave)
   );

   block_row_store #(
      .NUM_ROWS    (2),
      .FILLED_ROWS (1),
      .CNT_W       (CNT_W)
   ) dut2 (
      .clk      (clk),
      .rst      (rst),
      .store_io (bus2.slave)
   );

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Wall model: rows as plain masks, remaining = total set bits.
   row_t m_rows [NUM_ROWS];
   int   m_ptr  = 0;
   int   m_fill = 0;
   int   m_mode = MIdle;
   int   m_hit  = 0;
   bit   m_hv   = 1'b0;
   bit   m_clr  = 1'b0;

   function automatic int total_blocks();
      int s = 0;
      for (int i = 0; i < int'(NUM_ROWS); i++) s += $countones(m_rows[i]);
      return s;
   endfunction

   function automatic int next_ptr(input int p, input logic nf, input logic gn);
      if (nf) return 0;
      if (gn && (p < int'(NUM_ROWS) - 1)) return p + 1;
      return p;
   endfunction

   always @(posedge clk) begin
      m_hit <= 0;
      m_hv  <= 1'b0;
      if (rst) begin
         for (int i = 0; i < int'(NUM_ROWS); i++) m_rows[i] <= '0;
         m_ptr  <= 0;
         m_fill <= 0;
         m_mode <= MIdle;
         m_clr  <= 1'b0;
      end else if (bus.level_start) begin
         m_mode <= MFill;
         m_fill <= 0;
         m_ptr  <= 0;
         m_clr  <= 1'b0;
      end else if (m_mode == MIdle) begin
         m_ptr <= next_ptr(m_ptr, bus.new_frame, bus.go_next_line);
         m_clr <= 1'b0;
      end else if (m_mode == MFill) begin
         m_rows[m_fill] <= (m_fill < int'(FILLED_ROWS)) ? AllOnes : '0;
         m_fill <= m_fill + 1;
         if (m_fill == int'(NUM_ROWS) - 1) m_mode <= MRun;
      end else begin
         m_clr <= (total_blocks() == 0);
         if (bus.write_block_line_state) begin
            m_rows[m_ptr] <= m_rows[m_ptr] & bus.new_block_line_state;
            m_hit <= $countones(m_rows[m_ptr] & ~bus.new_block_line_state);
            m_hv  <= ((m_rows[m_ptr] & ~bus.new_block_line_state) != '0);
         end
         m_ptr <= next_ptr(m_ptr, bus.new_frame, bus.go_next_line);
      end
   end

   // Per-cycle comparison of the default instance against the model.
   always @(negedge clk) begin
      if (check_en) begin
         check("busy", int'(bus.busy), int'(m_mode == MFill));
         check("line", int'(bus.block_line_state), int'(m_rows[m_ptr]));
         check("blocks_hit", int'(bus.blocks_hit), m_hit);
         check("hit_valid", int'(bus.hit_valid), int'(m_hv));
         check("level_cleared", int'(bus.level_cleared), int'(m_clr));
         if (m_mode != MFill) begin
            check("remaining", int'(bus.blocks_remaining), total_blocks());
         end
      end
   end

   task automatic step(input bit ls, input bit nf, input bit gn, input bit wr, input row_t d);
      bus.level_start            = ls;
      bus.new_frame              = nf;
      bus.go_next_line           = gn;
      bus.write_block_line_state = wr;
      bus.new_block_line_state   = d;
      @(negedge clk);
      bus.level_start            = 1'b0;
      bus.new_frame              = 1'b0;
      bus.go_next_line           = 1'b0;
      bus.write_block_line_state = 1'b0;
   endtask

   task automatic step2(input bit ls, input bit nf, input bit gn, input bit wr, input row_t d);
      bus2.level_start            = ls;
      bus2.new_frame              = nf;
      bus2.go_next_line           = gn;
      bus2.write_block_line_state = wr;
      bus2.new_block_line_state   = d;
      @(negedge clk);
      bus2.level_start            = 1'b0;
      bus2.new_frame              = 1'b0;
      bus2.go_next_line           = 1'b0;
      bus2.write_block_line_state = 1'b0;
   endtask

   task automatic gos(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
   endtask

   task automatic wait_fill(input bit second, output int n);
      n = 0;
      while ((second ? bus2.busy : bus.busy) && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      bus.level_start = 1'b0;  bus.new_frame = 1'b0;  bus.go_next_line = 1'b0;
      bus.write_block_line_state = 1'b0;  bus.new_block_line_state = '0;
      bus2.level_start = 1'b0; bus2.new_frame = 1'b0; bus2.go_next_line = 1'b0;
      bus2.write_block_line_state = 1'b0; bus2.new_block_line_state = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_en = 1'b1;

      // Reset state
      check("rst_busy", int'(bus.busy), 0);
      check("rst_rem", int'(bus.blocks_remaining), 0);
      check("rst_line", int'(bus.block_line_state), 0);
      check("rst_cleared", int'(bus.level_cleared), 0);

      // Fill
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      wait_fill(1'b0, n);
      check("fill_cycles", n, 15);
      check("full_rem", int'(bus.blocks_remaining), 195);
      check("full_cleared", int'(bus.level_cleared), 0);
      check("full_line", int'(bus.block_line_state), 'h1FFF);

      // Single hit, advance, frame restart
      step(1'b0, 1'b0, 1'b0, 1'b1, 13'h1FFE);
      check("hit1", int'(bus.blocks_hit), 1);
      check("hv1", int'(bus.hit_valid), 1);
      check("rem194", int'(bus.blocks_remaining), 194);
      @(negedge clk);
      check("hv_pulse", int'(bus.hit_valid), 0);
      step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("row1", int'(bus.block_line_state), 'h1FFF);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("row0_back", int'(bus.block_line_state), 'h1FFE);

      // Write with advance, frame over advance, write with frame
      gos(3);
      step(1'b0, 1'b0, 1'b1, 1'b1, 13'h0000);
      check("hit13", int'(bus.blocks_hit), 13);
      check("row4", int'(bus.block_line_state), 'h1FFF);
      check("rem181", int'(bus.blocks_remaining), 181);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      gos(3);
      check("row3_zero", int'(bus.block_line_state), 0);
      step(1'b0, 1'b1, 1'b1, 1'b0, '0);
      check("nf_over_go", int'(bus.block_line_state), 'h1FFE);
      gos(2);
      step(1'b0, 1'b1, 1'b0, 1'b1, 13'h1FF0);
      check("hit4", int'(bus.blocks_hit), 4);
      check("wr_nf_ptr", int'(bus.block_line_state), 'h1FFE);
      check("rem177", int'(bus.blocks_remaining), 177);
      gos(2);
      check("row2", int'(bus.block_line_state), 'h1FF0);

      // New bits are not stored or counted
      gos(3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 13'h0F0F);
      check("hit5", int'(bus.blocks_hit), 5);
      check("rem172", int'(bus.blocks_remaining), 172);
      step(1'b0, 1'b0, 1'b0, 1'b1, 13'h1FFF);
      check("no_hit_hv", int'(bus.hit_valid), 0);
      check("no_hit_rem", int'(bus.blocks_remaining), 172);
      check("no_grow", int'(bus.block_line_state), 'h0F0F);

      // Pointer saturation
      gos(20);
      step(1'b0, 1'b0, 1'b0, 1'b1, 13'h0001);
      check("hit12", int'(bus.blocks_hit), 12);
      check("rem160", int'(bus.blocks_remaining), 160);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      gos(13);
      check("row13", int'(bus.block_line_state), 'h1FFF);
      gos(1);
      check("row14", int'(bus.block_line_state), 'h0001);
      gos(1);
      check("row14_sat", int'(bus.block_line_state), 'h0001);

      // Reset in the middle of a fill
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      repeat (4) @(negedge clk);
      check("mid_fill_busy", int'(bus.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_fill_busy", int'(bus.busy), 0);
      check("rst_fill_line", int'(bus.block_line_state), 0);
      check("rst_fill_rem", int'(bus.blocks_remaining), 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 13'h1FFF);
      check("idle_hv", int'(bus.hit_valid), 0);
      check("idle_rem", int'(bus.blocks_remaining), 0);
      gos(2);
      check("idle_row2", int'(bus.block_line_state), 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      wait_fill(1'b0, n);
      check("refill_cycles", n, 15);
      check("refill_rem", int'(bus.blocks_remaining), 195);

      // Two-row instance with only row 0 filled
      step2(1'b1, 1'b0, 1'b0, 1'b0, '0);
      wait_fill(1'b1, n);
      check("s_fill_cycles", n, 2);
      check("s_rem13", int'(bus2.blocks_remaining), 13);
      check("s_row0", int'(bus2.block_line_state), 'h1FFF);
      check("s_cleared0", int'(bus2.level_cleared), 0);
      step2(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("s_row1_empty", int'(bus2.block_line_state), 0);
      step2(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("s_row1_sat", int'(bus2.block_line_state), 0);
      step2(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("s_row0_back", int'(bus2.block_line_state), 'h1FFF);
      step2(1'b0, 1'b0, 1'b0, 1'b1, 13'h0000);
      check("s_hit13", int'(bus2.blocks_hit), 13);
      check("s_rem0", int'(bus2.blocks_remaining), 0);
      check("s_cleared_lag", int'(bus2.level_cleared), 0);
      @(negedge clk);
      check("s_cleared", int'(bus2.level_cleared), 1);
      step2(1'b1, 1'b0, 1'b0, 1'b0, '0);
      check("s_restart_cleared", int'(bus2.level_cleared), 0);
      check("s_restart_busy", int'(bus2.busy), 1);
      wait_fill(1'b1, n);
      check("s_refill_rem", int'(bus2.blocks_remaining), 13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
